// File: rtl/l2_strm_ctrl.sv
// l2_strm_ctrl: L2 stream-buffer controller.
// Starts host streams on a functional reset, prefetches cache lines through
// one shared host request port while tracking per-stream line credits, and
// turns one-hot L1 line reads into per-channel L2 URAM read addresses.
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   i_rst_v/i_rst_r/i_rst_ea   one-hot stream reset request with start EA
//   o_rst_v/o_rst_r            per-stream reset-done notification to L1
//   i_rd_v/i_rd_r              one-hot L1 line read request / accept
//   o_addr_v/r/sid/ptr         per-channel URAM read address (local sid, slot)
//   o_req_v/r/sid/ea           host cache-line read request
//   i_rsp_v/r/sid              host response, one per request, in order per stream
module l2_strm_ctrl #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned NSTRMS     = 64,
  parameter int unsigned L2_NSTRMS  = 16,
  parameter int unsigned L2_NCL     = 256,
  localparam int unsigned SID_W     = $clog2(NSTRMS),
  localparam int unsigned LSID_W    = $clog2(L2_NSTRMS),
  localparam int unsigned PTR_W     = $clog2(L2_NCL),
  localparam int unsigned CHANNELS  = NSTRMS / L2_NSTRMS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NSTRMS-1:0]            i_rst_v,
  output logic [NSTRMS-1:0]            i_rst_r,
  input  logic [ADDR_WIDTH-1:0]        i_rst_ea,
  output logic [NSTRMS-1:0]            o_rst_v,
  input  logic [NSTRMS-1:0]            o_rst_r,
  input  logic [NSTRMS-1:0]            i_rd_v,
  output logic [NSTRMS-1:0]            i_rd_r,
  output logic [CHANNELS-1:0]          o_addr_v,
  input  logic [CHANNELS-1:0]          o_addr_r,
  output logic [CHANNELS*LSID_W-1:0]   o_addr_sid,
  output logic [CHANNELS*PTR_W-1:0]    o_addr_ptr,
  output logic                         o_req_v,
  input  logic                         o_req_r,
  output logic [SID_W-1:0]             o_req_sid,
  output logic [ADDR_WIDTH-1:0]        o_req_ea,
  input  logic                         i_rsp_v,
  output logic                         i_rsp_r,
  input  logic [SID_W-1:0]             i_rsp_sid
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned CH_W  = SID_W - LSID_W;

  // Per-stream state
  logic [NSTRMS-1:0]     act_q, act_d, pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] nea_q [NSTRMS];
  logic [ADDR_WIDTH-1:0] nea_d [NSTRMS];
  logic [CNT_W-1:0]      outst_q [NSTRMS];
  logic [CNT_W-1:0]      outst_d [NSTRMS];
  logic [CNT_W-1:0]      vcnt_q [NSTRMS];
  logic [CNT_W-1:0]      vcnt_d [NSTRMS];
  logic [PTR_W-1:0]      rdptr_q [NSTRMS];
  logic [PTR_W-1:0]      rdptr_d [NSTRMS];

  // Host request stage and its arbiter
  logic                  req_v_q, req_v_d;
  logic [SID_W-1:0]      req_sid_q, req_sid_d;
  logic [ADDR_WIDTH-1:0] req_ea_q, req_ea_d;
  logic [SID_W-1:0]      rr_q, rr_d;
  logic [NSTRMS-1:0]     pf_elig;
  logic                  req_found, req_load, req_take;
  logic [SID_W-1:0]      req_gnt;
  logic [ADDR_WIDTH-1:0] gnt_ea;

  // Per-channel read address stage and arbiters
  logic [CHANNELS-1:0]        addr_v_q, addr_v_d;
  logic [CHANNELS*LSID_W-1:0] addr_sid_q, addr_sid_d;
  logic [CHANNELS*PTR_W-1:0]  addr_ptr_q, addr_ptr_d;
  logic [LSID_W-1:0]          rd_rr_q [CHANNELS];
  logic [LSID_W-1:0]          rd_rr_d [CHANNELS];
  logic [L2_NSTRMS-1:0]       rd_req_ch [CHANNELS];
  logic [LSID_W-1:0]          rd_gnt [CHANNELS];
  logic [SID_W-1:0]           rd_sid [CHANNELS];
  logic [CHANNELS-1:0]        rd_found;
  logic [NSTRMS-1:0]          rd_req, rd_acc;

  logic [NSTRMS-1:0] rst_acc, rsp_hit, req_hit;
  logic              rsp_r_q;

  // Reset handshake and prefetch eligibility. A stream accepting a reset this
  // cycle is eligible immediately so its first request can follow the accept.
  always_comb begin
    i_rst_r = '0;
    pf_elig = '0;
    rd_req  = '0;
    for (int s = 0; s < NSTRMS; s++) begin
      i_rst_r[s] = !pend_q[s] && (outst_q[s] == '0);
      pf_elig[s] = act_q[s] &&
                   ((SUM_W'(outst_q[s]) + SUM_W'(vcnt_q[s])) < SUM_W'(L2_NCL));
      rd_req[s]  = i_rd_v[s] && act_q[s] && (vcnt_q[s] != '0);
    end
    rst_acc = i_rst_v & i_rst_r;
    pf_elig = pf_elig | rst_acc;
  end

  // Round-robin prefetch arbiter over all streams
  always_comb begin
    req_found = 1'b0;
    req_gnt   = '0;
    for (int i = 0; i < NSTRMS; i++) begin
      if (!req_found && pf_elig[rr_q + SID_W'(i)]) begin
        req_found = 1'b1;
        req_gnt   = rr_q + SID_W'(i);
      end
    end
  end

  assign req_load = !req_v_q || o_req_r;
  assign req_take = req_load && req_found;
  assign gnt_ea   = rst_acc[req_gnt] ? i_rst_ea : nea_q[req_gnt];

  // Request stage: holds until the host takes it
  always_comb begin
    req_v_d   = req_v_q;
    req_sid_d = req_sid_q;
    req_ea_d  = req_ea_q;
    rr_d      = rr_q;
    if (req_load) req_v_d = req_found;
    if (req_take) begin
      req_sid_d = req_gnt;
      req_ea_d  = gnt_ea;
      rr_d      = req_gnt + SID_W'(1);
    end
  end

  // Per-channel read arbitration and address stage
  always_comb begin
    addr_v_d   = addr_v_q;
    addr_sid_d = addr_sid_q;
    addr_ptr_d = addr_ptr_q;
    rd_rr_d    = rd_rr_q;
    rd_acc     = '0;
    rd_found   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_req_ch[c] = rd_req[c*L2_NSTRMS +: L2_NSTRMS];
      rd_gnt[c]    = '0;
      for (int i = 0; i < L2_NSTRMS; i++) begin
        if (!rd_found[c] && rd_req_ch[c][rd_rr_q[c] + LSID_W'(i)]) begin
          rd_found[c] = 1'b1;
          rd_gnt[c]   = rd_rr_q[c] + LSID_W'(i);
        end
      end
      rd_sid[c] = {CH_W'(c), rd_gnt[c]};
      if (o_addr_r[c]) addr_v_d[c] = 1'b0;
      if (rd_found[c] && (!addr_v_q[c] || o_addr_r[c])) begin
        rd_acc[rd_sid[c]]                = 1'b1;
        addr_v_d[c]                      = 1'b1;
        addr_sid_d[c*LSID_W +: LSID_W]   = rd_gnt[c];
        addr_ptr_d[c*PTR_W +: PTR_W]     = rdptr_q[rd_sid[c]];
        rd_rr_d[c]                       = rd_gnt[c] + LSID_W'(1);
      end
    end
  end

  assign i_rd_r = rd_acc;

  // One-hot decode of this cycle's response and request load
  always_comb begin
    rsp_hit = '0;
    req_hit = '0;
    if (i_rsp_v)  rsp_hit[i_rsp_sid] = 1'b1;
    if (req_take) req_hit[req_gnt]   = 1'b1;
  end

  // Per-stream counters; a reset accept overrides the fill state
  always_comb begin
    act_d  = act_q;
    pend_d = pend_q & ~o_rst_r;
    for (int s = 0; s < NSTRMS; s++) begin
      nea_d[s]   = nea_q[s];
      outst_d[s] = outst_q[s] + CNT_W'(req_hit[s]) - CNT_W'(rsp_hit[s]);
      vcnt_d[s]  = vcnt_q[s] + CNT_W'(rsp_hit[s]) - CNT_W'(rd_acc[s]);
      rdptr_d[s] = rdptr_q[s] + PTR_W'(rd_acc[s]);
      if (rst_acc[s]) begin
        act_d[s]   = 1'b1;
        pend_d[s]  = 1'b1;
        vcnt_d[s]  = '0;
        rdptr_d[s] = '0;
        nea_d[s]   = i_rst_ea;
      end
      if (req_hit[s]) nea_d[s] = gnt_ea + ADDR_WIDTH'(CACHE_LINE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q      <= '0;
      pend_q     <= '0;
      for (int s = 0; s < NSTRMS; s++) begin
        nea_q[s]   <= '0;
        outst_q[s] <= '0;
        vcnt_q[s]  <= '0;
        rdptr_q[s] <= '0;
      end
      req_v_q    <= 1'b0;
      req_sid_q  <= '0;
      req_ea_q   <= '0;
      rr_q       <= '0;
      addr_v_q   <= '0;
      addr_sid_q <= '0;
      addr_ptr_q <= '0;
      for (int c = 0; c < CHANNELS; c++) rd_rr_q[c] <= '0;
      rsp_r_q    <= 1'b0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      nea_q      <= nea_d;
      outst_q    <= outst_d;
      vcnt_q     <= vcnt_d;
      rdptr_q    <= rdptr_d;
      req_v_q    <= req_v_d;
      req_sid_q  <= req_sid_d;
      req_ea_q   <= req_ea_d;
      rr_q       <= rr_d;
      addr_v_q   <= addr_v_d;
      addr_sid_q <= addr_sid_d;
      addr_ptr_q <= addr_ptr_d;
      rd_rr_q    <= rd_rr_d;
      rsp_r_q    <= 1'b1;
    end
  end

  assign o_rst_v    = pend_q;
  assign o_req_v    = req_v_q;
  assign o_req_sid  = req_sid_q;
  assign o_req_ea   = req_ea_q;
  assign o_addr_v   = addr_v_q;
  assign o_addr_sid = addr_sid_q;
  assign o_addr_ptr = addr_ptr_q;
  assign i_rsp_r    = rsp_r_q;

endmodule

// File: tb/tb_l2_strm_ctrl.sv
// Scoreboard bench for l2_strm_ctrl: directed stimulus pushes expected host
// requests and URAM addresses into queues; a monitor pops them on handshakes.
module tb_l2_strm_ctrl;

  typedef struct packed {
    logic [5:0]  sid;
    logic [63:0] ea;
  } req_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] sid;
    logic [7:0] ptr;
  } addr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] i_rst_v, i_rst_r, o_rst_v, o_rst_r, i_rd_v, i_rd_r;
  logic [63:0] i_rst_ea;
  logic [3:0]  o_addr_v, o_addr_r;
  logic [15:0] o_addr_sid;
  logic [31:0] o_addr_ptr;
  logic        o_req_v, o_req_r;
  logic [5:0]  o_req_sid;
  logic [63:0] o_req_ea;
  logic        i_rsp_v, i_rsp_r;
  logic [5:0]  i_rsp_sid;

  req_t        exp_req_q[$];
  addr_t       exp_addr_q[$];
  logic [5:0]  rsp_q[$];
  logic        loop_en;
  int          n_chk  = 0;
  int          n_pass = 0;

  l2_strm_ctrl dut (
    .clk(clk), .reset(reset),
    .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .i_rst_ea(i_rst_ea),
    .o_rst_v(o_rst_v), .o_rst_r(o_rst_r),
    .i_rd_v(i_rd_v), .i_rd_r(i_rd_r),
    .o_addr_v(o_addr_v), .o_addr_r(o_addr_r),
    .o_addr_sid(o_addr_sid), .o_addr_ptr(o_addr_ptr),
    .o_req_v(o_req_v), .o_req_r(o_req_r),
    .o_req_sid(o_req_sid), .o_req_ea(o_req_ea),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_sid(i_rsp_sid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic unexpected(input string name, input logic [63:0] a, input logic [63:0] b);
    n_chk++;
    $display("FAIL %s: unexpected handshake sid=%0d val=%0d", name, a, b);
  endtask

  // Monitor: compare every handshake against the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (o_req_v && o_req_r) begin
        if (exp_req_q.size() == 0) unexpected("req", 64'(o_req_sid), o_req_ea);
        else begin
          req_t e;
          e = exp_req_q.pop_front();
          check("req_sid", 64'(o_req_sid), 64'(e.sid));
          check("req_ea", o_req_ea, e.ea);
        end
        if (loop_en) rsp_q.push_back(o_req_sid);
      end
      for (int c = 0; c < 4; c++) begin
        if (o_addr_v[c] && o_addr_r[c]) begin
          if (exp_addr_q.size() == 0) unexpected("addr", 64'(o_addr_sid[c*4 +: 4]), 64'(o_addr_ptr[c*8 +: 8]));
          else begin
            addr_t a;
            a = exp_addr_q.pop_front();
            check("addr_ch", 64'(c), 64'(a.ch));
            check("addr_sid", 64'(o_addr_sid[c*4 +: 4]), 64'(a.sid));
            check("addr_ptr", 64'(o_addr_ptr[c*8 +: 8]), 64'(a.ptr));
          end
        end
      end
    end
  end

  // Responder: returns queued responses one per cycle
  initial begin
    i_rsp_v   = 1'b0;
    i_rsp_sid = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_q.size() != 0) begin
        i_rsp_v   = 1'b1;
        i_rsp_sid = rsp_q.pop_front();
      end else begin
        i_rsp_v   = 1'b0;
        i_rsp_sid = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_drain(input string name, input int budget);
    int n = 0;
    while (exp_req_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_req_q.size()), 64'd0);
  endtask

  task automatic wait_rsp_drain(input string name, input int budget);
    int n = 0;
    while (rsp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(rsp_q.size()), 64'd0);
  endtask

  initial begin
    reset    = 1'b0;
    i_rst_v  = '0;
    i_rst_ea = '0;
    o_rst_r  = '1;
    i_rd_v   = '0;
    o_addr_r = '1;
    o_req_r  = 1'b1;
    loop_en  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_v", 64'(o_req_v), 64'd0);
    check("rst_addr_v", 64'(o_addr_v), 64'd0);
    check("rst_rst_v", o_rst_v, 64'd0);
    check("rst_rsp_r", 64'(i_rsp_r), 64'd0);
    drive_edge();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rsp_r_run", 64'(i_rsp_r), 64'd1);

    // Read before any stream reset
    drive_edge();
    i_rd_v = 64'd2;
    @(negedge clk);
    check("rd_r_inactive", 64'(i_rd_r[1]), 64'd0);
    drive_edge();
    i_rd_v = '0;
    @(negedge clk);
    check("idle_addr_v", 64'(o_addr_v), 64'd0);
    check("idle_req_v", 64'(o_req_v), 64'd0);

    // Stream 1 from EA 4, responses looped back; fills to the 256-line limit
    for (int n = 0; n < 256; n++) exp_req_q.push_back('{sid: 6'd1, ea: 64'd4 + 64'd128 * 64'(n)});
    drive_edge();
    o_rst_r  = '0;
    i_rst_v  = 64'd2;
    i_rst_ea = 64'd4;
    @(negedge clk);
    check("rst_r_s1", 64'(i_rst_r[1]), 64'd1);
    drive_edge();
    i_rst_v = '0;
    @(negedge clk);
    check("rst_v_s1", 64'(o_rst_v[1]), 64'd1);
    check("rst_r_s1_pend", 64'(i_rst_r[1]), 64'd0);
    drive_edge();
    @(negedge clk);
    check("rst_v_s1_hold", 64'(o_rst_v[1]), 64'd1);
    drive_edge();
    o_rst_r = 64'd2;
    drive_edge();
    o_rst_r = '1;
    @(negedge clk);
    check("rst_v_s1_clr", o_rst_v, 64'd0);
    wait_req_drain("s1_fill_drain", 600);
    repeat (4) @(negedge clk);
    check("s1_full_no_req", 64'(o_req_v), 64'd0);

    // Two reads of stream 1; each frees a credit for one more prefetch
    exp_addr_q.push_back('{ch: 2'd0, sid: 4'd1, ptr: 8'd0});
    exp_req_q.push_back('{sid: 6'd1, ea: 64'd4 + 64'd128 * 64'd256});
    drive_edge();
    i_rd_v = 64'd2;
    @(negedge clk);
    check("rd_r_s1_a", 64'(i_rd_r[1]), 64'd1);
    drive_edge();
    i_rd_v = '0;
    repeat (3) drive_edge();
    exp_addr_q.push_back('{ch: 2'd0, sid: 4'd1, ptr: 8'd1});
    exp_req_q.push_back('{sid: 6'd1, ea: 64'd4 + 64'd128 * 64'd257});
    i_rd_v = 64'd2;
    @(negedge clk);
    check("rd_r_s1_b", 64'(i_rd_r[1]), 64'd1);
    drive_edge();
    i_rd_v = '0;
    wait_req_drain("s1_refill_drain", 50);
    repeat (4) @(negedge clk);
    check("s1_addr_drain", 64'(exp_addr_q.size()), 64'd0);

    // Streams 17 and 2, responses withheld: round-robin interleave up to 256 each
    loop_en = 1'b0;
    for (int n = 0; n < 256; n++) begin
      exp_req_q.push_back('{sid: 6'd17, ea: 64'd8 + 64'd128 * 64'(n)});
      exp_req_q.push_back('{sid: 6'd2, ea: 64'd16 + 64'd128 * 64'(n)});
    end
    drive_edge();
    i_rst_v  = 64'd1 << 17;
    i_rst_ea = 64'd8;
    @(negedge clk);
    check("rst_r_s17", 64'(i_rst_r[17]), 64'd1);
    drive_edge();
    i_rst_v  = 64'd1 << 2;
    i_rst_ea = 64'd16;
    @(negedge clk);
    check("rst_r_s2", 64'(i_rst_r[2]), 64'd1);
    check("rst_v_s17", 64'(o_rst_v[17]), 64'd1);
    drive_edge();
    i_rst_v = '0;
    wait_req_drain("s17_s2_drain", 1200);
    repeat (4) @(negedge clk);
    check("credit_limit_no_req", 64'(o_req_v), 64'd0);

    // Re-reset of stream 17 with 256 lines in flight must stall
    drive_edge();
    i_rst_v  = 64'd1 << 17;
    i_rst_ea = 64'd32;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_r_s17_busy", 64'(i_rst_r[17]), 64'd0);
      drive_edge();
    end
    i_rst_v = '0;
    for (int n = 0; n < 256; n++) begin
      rsp_q.push_back(6'd17);
      rsp_q.push_back(6'd2);
    end
    wait_rsp_drain("rsp_drain", 600);
    repeat (2) @(negedge clk);
    check("rst_r_s17_drained", 64'(i_rst_r[17]), 64'd1);
    check("drained_no_req", 64'(o_req_v), 64'd0);

    // Back-pressure on channel 0 and on the host request port
    drive_edge();
    o_req_r  = 1'b0;
    o_addr_r = 4'b1110;
    exp_addr_q.push_back('{ch: 2'd0, sid: 4'd2, ptr: 8'd0});
    i_rd_v = 64'd1 << 2;
    @(negedge clk);
    check("rd_r_s2", 64'(i_rd_r[2]), 64'd1);
    drive_edge();
    i_rd_v = 64'd2;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_rd_r_s1", 64'(i_rd_r[1]), 64'd0);
      check("bp_addr_v0", 64'(o_addr_v[0]), 64'd1);
      check("bp_addr_sid0", 64'(o_addr_sid[3:0]), 64'd2);
      check("bp_addr_ptr0", 64'(o_addr_ptr[7:0]), 64'd0);
      drive_edge();
    end
    @(negedge clk);
    check("bp_req_v", 64'(o_req_v), 64'd1);
    check("bp_req_sid", 64'(o_req_sid), 64'd2);
    check("bp_req_ea", o_req_ea, 64'd16 + 64'd128 * 64'd256);
    drive_edge();
    exp_addr_q.push_back('{ch: 2'd0, sid: 4'd1, ptr: 8'd2});
    o_addr_r = '1;
    @(negedge clk);
    check("rd_r_s1_release", 64'(i_rd_r[1]), 64'd1);
    drive_edge();
    i_rd_v = '0;
    drive_edge();
    exp_addr_q.push_back('{ch: 2'd1, sid: 4'd1, ptr: 8'd0});
    i_rd_v = 64'd1 << 17;
    @(negedge clk);
    check("rd_r_s17", 64'(i_rd_r[17]), 64'd1);
    drive_edge();
    i_rd_v = '0;
    repeat (3) @(negedge clk);
    check("bp_addr_drain", 64'(exp_addr_q.size()), 64'd0);
    check("bp_req_hold_sid", 64'(o_req_sid), 64'd2);

    // Async reset mid-operation clears registered outputs at once
    drive_edge();
    o_rst_r  = '0;
    o_addr_r = '0;
    i_rst_v  = 64'd1 << 3;
    i_rst_ea = 64'd64;
    i_rd_v   = 64'd2;
    drive_edge();
    i_rst_v = '0;
    i_rd_v  = '0;
    @(negedge clk);
    check("pre_rst_rst_v3", 64'(o_rst_v[3]), 64'd1);
    check("pre_rst_addr_v0", 64'(o_addr_v[0]), 64'd1);
    check("pre_rst_req_v", 64'(o_req_v), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_req_v", 64'(o_req_v), 64'd0);
    check("async_addr_v", 64'(o_addr_v), 64'd0);
    check("async_rst_v", o_rst_v, 64'd0);
    check("async_rsp_r", 64'(i_rsp_r), 64'd0);
    check("end_req_q", 64'(exp_req_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l2_strm_ctrl.md
Name: l2_strm_ctrl

Overview:
L2 stream-buffer controller for 64 host streams. Each stream is started by a functional reset carrying a start effective address (EA). The block then prefetches cache lines over a single shared request port and tracks how many lines are resident in L2 per stream. It converts one-hot L1 read requests into per-channel L2 URAM read addresses (local stream id plus line pointer) and sits between the L1 stream buffers, the L2 URAM banks and the host request/response interface.

Parameters:
addr_width, 64, host EA width in bits.
cache_line, 128, host cache line size in bytes; log2 gives cache_line_width.
nstrms, 64, number of streams; log2 gives nstrms_width.
l2_nstrms, 16, streams per L2 channel; log2 gives l2_nstrms_width.
l2_ncl, 256, L2 lines per stream; log2 gives l2_ncl_width.
channels, nstrms/l2_nstrms (4), number of L2 URAM channels.

Ports:
clk  in  1  clock; single clock domain.
reset  in  1  asynchronous, active-low reset.
i_rst_v  in  nstrms  one-hot stream reset request.
i_rst_r  out  nstrms  per-stream reset ready.
i_rst_ea  in  addr_width  start EA of the stream being reset.
o_rst_v  out  nstrms  stream-reset-done notification to L1.
o_rst_r  in  nstrms  L1 accepts the notification.
i_rd_v  in  nstrms  L1 line read request, one-hot.
i_rd_r  out  nstrms  read request accepted.
o_addr_v  out  channels  URAM read address valid, one per channel.
o_addr_r  in  channels  URAM read ready.
o_addr_sid  out  channels*l2_nstrms_width  local stream id per channel.
o_addr_ptr  out  channels*l2_ncl_width  line slot per channel.
o_req_v  out  1  host read request valid.
o_req_r  in  1  host read request ready.
o_req_sid  out  nstrms_width  requesting stream.
o_req_ea  out  addr_width  cache-line EA to fetch.
i_rsp_v  in  1  host response valid; one per request.
i_rsp_r  out  1  response ready; tied to 1 outside reset.
i_rsp_sid  in  nstrms_width  stream of the returned line.

Behaviour:
- Stream-to-channel mapping: stream s maps to channel s[nstrms_width-1:l2_nstrms_width] and local sid s[l2_nstrms_width-1:0]. Stream 1 → channel 0 / sid 1; stream 17 → channel 1 / sid 1.
- Per-stream state: active flag, next EA, outstanding count (0..l2_ncl), valid count (0..l2_ncl), read pointer (l2_ncl_width bits, wraps mod l2_ncl), rst_pend flag.
- While reset is asserted all state and every registered output (o_rst_v, o_addr_v, o_req_v, sids, ptrs, EAs) is 0. i_rsp_r is 0 during reset and 1 otherwise.
- Reset accept:
  - i_rst_r[s] = !rst_pend[s] && outstanding[s]==0.
  - On i_rst_v[s] && i_rst_r[s]: active=1, next EA = i_rst_ea, valid=0, read pointer=0, rst_pend=1.
  - i_rst_v with more than one bit set is illegal.
  - A reset to a stream with requests in flight stalls (i_rst_r=0) until they drain and the prior notification is accepted.
- Reset notification: o_rst_v[s] = rst_pend[s], asserted the cycle after acceptance. It clears on o_rst_r[s].
- Prefetch:
  - A stream is eligible when active and outstanding+valid < l2_ncl.
  - A round-robin arbiter across the 64 streams loads a registered o_req stage when it is empty or draining (!o_req_v || o_req_r).
  - o_req_v/sid/ea hold stable until o_req_r.
  - On load: outstanding++, next EA += cache_line (wraps modulo 2^addr_width).
  - The first request for a stream can appear the cycle after its reset is accepted.
- Response: on i_rsp_v, outstanding--, valid++ for i_rsp_sid. Responses are in order per stream. A response and a request load for the same stream in the same cycle are both applied.
- Read:
  - Each channel has a registered output stage and a round-robin arbiter over its 16 streams.
  - i_rd_r[s] = active && valid>0 && won arbitration && (!o_addr_v[c] || o_addr_r[c]).
  - On accept, next cycle o_addr_v[c]=1 with sid = local sid and ptr = read pointer. Then read pointer++ (wraps 255→0) and valid--, which frees a credit for a new prefetch.
  - A read to an inactive or empty stream is not accepted (i_rd_r=0) and is not dropped.
- Simultaneous read accept and response on the same stream: valid is unchanged.

Test Plan:
- Read before any reset: i_rd_v=2 → i_rd_r[1]=0; no o_addr_v; no o_req_v.
- Reset stream 1, EA 4: i_rst_r[1]=1. Next cycle o_rst_v[1]=1. Requests sid 1 issue with EA 4, 132, 260, … with o_req_r=1 and responses looped back one cycle later.
- Reset streams 1, 17, 2 (EA 4, 8, 16) on consecutive cycles, then re-reset stream 1 with EA 32 while its requests are in flight → i_rst_r[1]=0; EA 32 is never requested. o_req interleaves sids 1, 2, 17 round-robin.
- Credit limit: o_req_r=1, responses withheld → exactly 256 requests per stream, then no further requests for that stream.
- Read stream 1, then stream 2, after fill: o_addr_v[0] with sid 1/ptr 0, then sid 2/ptr 0. Channel 1 stays idle. A second read of stream 1 gives ptr 1.
- Back-pressure: o_addr_r[0]=0 → o_addr_v[0] holds sid/ptr stable and i_rd_r for channel-0 streams is 0. Asserting reset mid-operation clears o_req_v, o_addr_v and o_rst_v immediately.
